// File: rtl/bias_stream_gen_pkg.sv
// Shared constants for the bias coefficient streamers.
// Holds default widths, per-layer kernel counts, ORDER encodings and FSM states.
package bias_stream_gen_pkg;

    localparam int COEFF_WIDTH_DEF = 16;

    // Kernel count of the first conv layer
    localparam int KERN_S_K_1 = 16;

    // Emission ordering
    localparam int ORDER_BIAS_MAJOR = 0;
    localparam int ORDER_SET_MAJOR  = 1;

    // Sequencer FSM
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Counter width that stays at least one bit for degenerate sizes
    function automatic int clog2_min2(input int n);
        return $clog2(n < 2 ? 2 : n);
    endfunction

endpackage

// File: rtl/bias_skid_buf.sv
// Two-entry out/skid buffer behind a 1-cycle-latency ROM, with in-flight tracking.
// Ports: issue (read issued now), rdata (ROM q), full_n (sink ready),
// can_issue, will_empty (empty after this edge, given no issue), write, data.
module bias_skid_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [WIDTH-1:0] rdata,
    input  logic             full_n,
    output logic             can_issue,
    output logic             will_empty,
    output logic             write,
    output logic [WIDTH-1:0] data
);

    logic             inflight;
    logic             out_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] skid_data;
    logic             drain;
    logic             take;
    logic [1:0]       occ;

    assign drain = out_valid & full_n;
    assign take  = ~out_valid | drain;
    assign write = drain;
    assign data  = out_data;

    // Reserve a slot for every outstanding read, crediting this cycle's drain
    assign occ = 2'(out_valid) + 2'(skid_valid) + 2'(inflight);
    assign can_issue = occ <= ({1'b0, drain} + 2'd1);

    assign will_empty = ~inflight & ~skid_valid & take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= 1'b0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else begin
            inflight <= issue;
            if (take) begin
                if (skid_valid) begin
                    // Older skid word goes out first; a returning word refills skid
                    out_data   <= skid_data;
                    out_valid  <= 1'b1;
                    skid_valid <= inflight;
                    if (inflight) skid_data <= rdata;
                end else begin
                    out_valid <= inflight;
                    if (inflight) out_data <= rdata;
                end
            end else if (inflight) begin
                skid_data  <= rdata;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom.sv
// Synchronous single-port ROM, one cycle read latency (ce/addr -> q).
// Ports: clk, ce, addr (read request), q (registered word).
// The image arrives as init_data (word i at bits [i*data_width +: data_width]),
// produced by the build flow from mem_file; an empty mem_file gives a zero ROM.
module rom
    import bias_stream_gen_pkg::*;
#(
    parameter int    mem_size   = 16,
    parameter int    data_width = 16,
    parameter string mem_file   = "",
    parameter logic [mem_size*data_width-1:0] init_data = '0
) (
    input  logic                          clk,
    input  logic                          ce,
    input  logic [clog2_min2(mem_size)-1:0] addr,
    output logic [data_width-1:0]         q
);

    localparam int AW    = clog2_min2(mem_size);
    localparam int DEPTH = 1 << AW;

    logic [data_width-1:0] mem [DEPTH];

    // Pad to a power-of-two depth so every addr value is in range
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (mem_file != "" && i < mem_size) begin : g_img
            assign mem[i] = init_data[i*data_width +: data_width];
        end else begin : g_pad
            assign mem[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ce) q <= mem[addr];
    end

endmodule

// File: rtl/bias_stream_gen.sv
// Streams per-kernel bias words from a ROM into a FIFO write port.
// Ports: ap_clk, ap_rst_n, ap_start/ap_idle/ap_done (control),
// output_V_din/output_V_full_n/output_V_write (FIFO side).
module bias_stream_gen
    import bias_stream_gen_pkg::*;
#(
    parameter int    COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter int    NUM_KERNELS = KERN_S_K_1,
    parameter int    REPEAT      = 1,
    parameter int    ORDER       = ORDER_BIAS_MAJOR,
    parameter int    NUM_PASSES  = 1,
    parameter string MEM_FILE    = "./bias.mem",
    parameter logic [NUM_KERNELS*COEFF_WIDTH-1:0] ROM_INIT = '0
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   ap_start,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic [COEFF_WIDTH-1:0] output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write
);

    localparam int KW = clog2_min2(NUM_KERNELS);
    localparam int RW = clog2_min2(REPEAT);
    localparam int PW = clog2_min2(NUM_PASSES);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [KW-1:0]          kern;
    logic [RW-1:0]          rep;
    logic [PW-1:0]          pass;
    logic                   issue;
    logic                   can_issue;
    logic                   will_empty;
    logic                   kern_last;
    logic                   rep_last;
    logic                   pass_last;
    logic                   seq_end;
    logic [COEFF_WIDTH-1:0] q;

    assign kern_last = kern == KW'(NUM_KERNELS - 1);
    assign rep_last  = rep == RW'(REPEAT - 1);
    assign seq_end   = kern_last & rep_last;
    // A zero pass count never reaches its last pass
    assign pass_last = (NUM_PASSES != 0) && (pass == PW'(NUM_PASSES - 1));
    assign issue     = (state == ST_RUN) & can_issue;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (ap_start) state_nxt = ST_RUN;
            ST_RUN:   if (issue && seq_end && pass_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (will_empty) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= ST_IDLE;
            kern    <= '0;
            rep     <= '0;
            pass    <= '0;
            ap_idle <= 1'b1;
            ap_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            ap_idle <= state_nxt == ST_IDLE;
            // Done lands the cycle after the final word leaves
            ap_done <= (state == ST_DRAIN) && will_empty;
            if (state == ST_IDLE) begin
                kern <= '0;
                rep  <= '0;
                pass <= '0;
            end else if (issue) begin
                if (ORDER == ORDER_SET_MAJOR) begin
                    kern <= kern_last ? '0 : kern + 1'b1;
                    if (kern_last) rep <= rep_last ? '0 : rep + 1'b1;
                end else begin
                    rep <= rep_last ? '0 : rep + 1'b1;
                    if (rep_last) kern <= kern_last ? '0 : kern + 1'b1;
                end
                if (seq_end) pass <= pass + 1'b1;
            end
        end
    end

    rom #(
        .mem_size   (NUM_KERNELS),
        .data_width (COEFF_WIDTH),
        .mem_file   (MEM_FILE),
        .init_data  (ROM_INIT)
    ) u_rom (
        .clk  (ap_clk),
        .ce   (issue),
        .addr (kern),
        .q    (q)
    );

    bias_skid_buf #(
        .WIDTH (COEFF_WIDTH)
    ) u_buf (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .issue      (issue),
        .rdata      (q),
        .full_n     (output_V_full_n),
        .can_issue  (can_issue),
        .will_empty (will_empty),
        .write      (output_V_write),
        .data       (output_V_din)
    );

endmodule

// File: tb/tb_bias_stream_gen.sv
// Testbench for bias_stream_gen: table-driven runs plus reset and free-run sequences.
// Three DUT configurations share one clock; each has its own control signals.
module tb_bias_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [3];
    logic        start  [3];
    logic        full_n [3];
    logic        idle   [3];
    logic        done   [3];
    logic        write  [3];
    logic [15:0] din    [3];

    int total = 0;
    int bad   = 0;
    int cnt;

    typedef struct {
        int          dut;
        int          mode;  // 0: full_n high, 1: pseudo-random, 2: low 20 cycles
        int          n;
        logic [15:0] exp [16];
    } case_t;

    case_t cases [4];

    bias_stream_gen #(
        .COEFF_WIDTH(16), .NUM_KERNELS(4), .REPEAT(3), .ORDER(0),
        .NUM_PASSES(1), .ROM_INIT(64'h0013_0012_0011_0010)
    ) u_a (
        .ap_clk(clk), .ap_rst_n(rst_n[0]), .ap_start(start[0]),
        .ap_idle(idle[0]), .ap_done(done[0]), .output_V_din(din[0]),
        .output_V_full_n(full_n[0]), .output_V_write(write[0])
    );

    bias_stream_gen #(
        .COEFF_WIDTH(16), .NUM_KERNELS(4), .REPEAT(2), .ORDER(1),
        .NUM_PASSES(2), .ROM_INIT(64'h0013_0012_0011_0010)
    ) u_b (
        .ap_clk(clk), .ap_rst_n(rst_n[1]), .ap_start(start[1]),
        .ap_idle(idle[1]), .ap_done(done[1]), .output_V_din(din[1]),
        .output_V_full_n(full_n[1]), .output_V_write(write[1])
    );

    bias_stream_gen #(
        .COEFF_WIDTH(16), .NUM_KERNELS(1), .REPEAT(1), .ORDER(0),
        .NUM_PASSES(0), .ROM_INIT(16'h0010)
    ) u_c (
        .ap_clk(clk), .ap_rst_n(rst_n[2]), .ap_start(start[2]),
        .ap_idle(idle[2]), .ap_done(done[2]), .output_V_din(din[2]),
        .output_V_full_n(full_n[2]), .output_V_write(write[2])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First write is expected 3 sampled cycles after start is driven:
    // RUN cycle issues, ROM returns, out register presents the word.
    task automatic run_case(input int ci);
        int          d;
        int          idx;
        int          last_k;
        bit          seen;
        logic        pf;
        logic [15:0] pd;
        logic [15:0] lfsr;
        d      = cases[ci].dut;
        idx    = 0;
        last_k = 0;
        seen   = 1'b0;
        pf     = 1'b1;
        pd     = '0;
        lfsr   = 16'hace1;
        @(negedge clk);
        start[d]  = 1'b1;
        full_n[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int k = 1; k < 300 && !seen; k++) begin
            case (cases[ci].mode)
                1: begin
                    full_n[d] = lfsr[0];
                    lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hb400 : 16'h0);
                end
                2:       full_n[d] = (k > 20);
                default: full_n[d] = 1'b1;
            endcase
            #1;
            chk("wr_gate", {31'b0, write[d] & ~full_n[d]}, 0);
            if (cases[ci].mode == 1 && !pf && idx > 0 && idx < cases[ci].n)
                chk("din_hold", din[d], pd);
            if (write[d]) begin
                if (idx == 0) begin
                    if (cases[ci].mode == 0) chk("first_lat", k, 3);
                    if (cases[ci].mode == 2) chk("first_lat", k, 21);
                end else if (cases[ci].mode != 1) begin
                    chk("no_gap", k, last_k + 1);
                end
                if (idx < cases[ci].n) chk("din", din[d], cases[ci].exp[idx]);
                else chk("extra_write", idx, cases[ci].n);
                idx++;
                last_k = k;
            end
            if (done[d]) begin
                seen = 1'b1;
                chk("done_cnt", idx, cases[ci].n);
                if (cases[ci].mode != 1) chk("done_lat", k, last_k + 1);
                chk("idle_at_done", {31'b0, idle[d]}, 1);
            end
            pf = full_n[d];
            pd = din[d];
            if (!seen) @(negedge clk);
        end
        chk("done_seen", {31'b0, seen}, 1);
        @(negedge clk);
        #1;
        chk("done_pulse", {31'b0, done[d]}, 0);
        chk("idle_after", {31'b0, idle[d]}, 1);
        full_n[d] = 1'b1;
    endtask

    initial begin
        cases[0].dut  = 0;
        cases[0].mode = 0;
        cases[0].n    = 12;
        cases[0].exp  = '{16'h10, 16'h10, 16'h10, 16'h11, 16'h11, 16'h11,
                          16'h12, 16'h12, 16'h12, 16'h13, 16'h13, 16'h13,
                          16'h0, 16'h0, 16'h0, 16'h0};
        cases[1].dut  = 1;
        cases[1].mode = 0;
        cases[1].n    = 16;
        cases[1].exp  = '{16'h10, 16'h11, 16'h12, 16'h13,
                          16'h10, 16'h11, 16'h12, 16'h13,
                          16'h10, 16'h11, 16'h12, 16'h13,
                          16'h10, 16'h11, 16'h12, 16'h13};
        cases[2]      = cases[0];
        cases[2].mode = 1;
        cases[3]      = cases[0];
        cases[3].mode = 2;

        for (int d = 0; d < 3; d++) begin
            rst_n[d]  = 1'b0;
            start[d]  = 1'b0;
            full_n[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_idle", {31'b0, idle[d]}, 1);
            chk("rst_write", {31'b0, write[d]}, 0);
            chk("rst_done", {31'b0, done[d]}, 0);
            chk("rst_din", din[d], 0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        for (int ci = 0; ci < 4; ci++) run_case(ci);

        // Free-running single-entry stream: a word every cycle, never done
        @(negedge clk);
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (k >= 3) begin
                chk("fr_write", {31'b0, write[2]}, 1);
                chk("fr_din", din[2], 16'h10);
            end
            chk("fr_done", {31'b0, done[2]}, 0);
            @(negedge clk);
        end
        rst_n[2] = 1'b0;

        // Reset while the fifth word is on the port, then a clean rerun
        @(negedge clk);
        start[0]  = 1'b1;
        full_n[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        cnt = 0;
        for (int k = 1; k < 100 && cnt < 5; k++) begin
            #1;
            if (write[0]) begin
                chk("pre_rst_din", din[0], cases[0].exp[cnt]);
                cnt++;
            end
            if (cnt < 5) @(negedge clk);
        end
        chk("pre_rst_cnt", cnt, 5);
        rst_n[0] = 1'b0;
        #1;
        chk("mid_rst_write", {31'b0, write[0]}, 0);
        chk("mid_rst_idle", {31'b0, idle[0]}, 1);
        chk("mid_rst_din", din[0], 0);
        chk("mid_rst_done", {31'b0, done[0]}, 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        run_case(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bias_stream_gen.md
Name: bias_stream_gen

Overview:
Parametrised bias coefficient source for the conv layer pipeline. It streams per-kernel bias values from an internal synchronous ROM into a FIFO-style write port (din/full_n/write). It supports configurable kernel count, coefficient width, per-bias repeat count, ordering mode and pass count. It sustains one word per clock under backpressure, and its start/done handshake lets the layer controller re-arm it per frame.

Parameters:
COEFF_WIDTH, 16, bias word width in bits
NUM_KERNELS, 16, number of bias entries in ROM (>=1)
REPEAT, 1, times each bias is emitted per pass (>=1)
ORDER, 0, 0 = bias-major (b0 x REPEAT, b1 x REPEAT, ...); 1 = set-major (b0..bK-1, repeated REPEAT times)
NUM_PASSES, 1, passes per start; 0 = free-running, never done
MEM_FILE, "./bias.mem", ROM init file (hex, one word per line)

Ports:
ap_clk  in  1  clock, all logic rising-edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  level; sampled only in IDLE, starts a run
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse after last word of last pass is written
output_V_din  out  COEFF_WIDTH  bias word
output_V_full_n  in  1  downstream can accept
output_V_write  out  1  word transferred this cycle

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0, out_valid=0, skid_valid=0; ap_idle=1, ap_done=0, output_V_write=0, output_V_din=0.
- output_V_write = out_valid & output_V_full_n (combinational from full_n). output_V_din comes from out_data register, never combinational from ROM.
- ROM read latency is exactly 1 cycle (ce/addr at cycle n, q at n+1).
- Issue rule: a ROM read is issued when state=RUN, the element sequence is not exhausted, and free slots (out + skid) minus in-flight reads is >= 1. Result: zero bubbles when full_n is held high, with first word valid 2 cycles after start is accepted.
- ROM return goes to out_data if out slot is free or being drained this cycle; otherwise it goes to skid. skid moves to out on the next drain. No word is ever dropped or duplicated. Ordering is strictly preserved.
- Address sequence:
  - ORDER=0: kern increments after rep reaches REPEAT-1.
  - ORDER=1: rep increments after kern reaches NUM_KERNELS-1.
  - Both counters wrap to 0 at pass end. The pass counter increments at wrap.
- Counter widths: $clog2(max(N,2)). NUM_KERNELS=1 and REPEAT=1 must work (constant address).
- States:
  - IDLE: ap_start=1 -> RUN, clear counters.
  - RUN: issues reads. When last read of last pass is issued -> DRAIN. With NUM_PASSES=0, stays in RUN forever.
  - DRAIN: waits until in-flight, skid and out are all empty, then pulses ap_done, -> IDLE.
- ap_done and ap_idle are registered. ap_start held high through done restarts in the cycle after return to IDLE.
- full_n low for any duration: out_data and write stall. At most 2 words are buffered, and reads stop issuing.
- full_n toggling every cycle: every transfer carries the correct next word.
- Reset mid-run: all state is discarded immediately. The next start begins at element 0 of pass 0.

Decomposition:
- Shared package/header: coeff_width default, per-layer kernel counts (kern_s_k_N), ORDER encodings as named constants.
- Sub-modules:
  - rom: the existing codebase ROM, instantiated with mem_size=NUM_KERNELS, data_width=COEFF_WIDTH, mem_file=MEM_FILE.
  - bias_skid_buf: the out/skid two-entry buffer with in-flight tracking, reusable by other ROM-fed streamers.
- Sequencer and FSM stay in the top module.

Test Plan:
1. NUM_KERNELS=4, REPEAT=3, ORDER=0, NUM_PASSES=1, ROM={0x10,0x11,0x12,0x13}, full_n=1, start pulse -> 12 consecutive writes 10,10,10,11,11,11,12,12,12,13,13,13 with no gaps; first write 2 cycles after start; ap_done exactly 1 cycle after last write; ap_idle returns high.
2. Same ROM, ORDER=1, REPEAT=2, NUM_PASSES=2 -> 16 writes: (10,11,12,13) x4, single done pulse at end.
3. Case 1 with full_n driven by pseudo-random 50% pattern -> write only when full_n=1; sequence identical to case 1; din stable while full_n=0.
4. full_n=0 for 20 cycles after start, then 1 -> no writes while low, then 12 writes back-to-back.
5. NUM_PASSES=0, NUM_KERNELS=1, REPEAT=1 -> continuous 0x10 every cycle; ap_done never asserts.
6. Assert ap_rst_n low after 5th write of case 1 -> write=0, ap_idle=1 immediately; a new start emits from 10 again, full 12 words.
